// File: rtl/vga_scan_gen_if.sv
// Scan-timing bundle between the VGA timing generator and the pixel-colour logic.
// The generator is the master: it owns the coordinates, strobes and pins.
// The colour logic is the slave: it returns the colour for the current coordinates.
interface vga_scan_gen_if;
  logic [11:0] rgb_in;
  logic        pix_en;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgb_out;
  logic        frame_tick;
  logic [7:0]  frame_count;

  modport master (
    input  rgb_in,
    output pix_en, hCount, vCount, bright,
    output hSync, vSync, rgb_out,
    output frame_tick, frame_count
  );

  modport slave (
    output rgb_in,
    input  pix_en, hCount, vCount, bright,
    input  hSync, vSync, rgb_out,
    input  frame_tick, frame_count
  );
endinterface

// File: rtl/vga_scan_gen.sv
// 640x480@60 Hz scan generator and output stage.
// It divides the system clock down to a pixel enable and runs the column/line
// counters. It decodes sync and visible-area timing, and delays sync and colour
// through a common pipe so the pins stay aligned. It also flags the start of
// vertical blank once per frame.
module vga_scan_gen #(
  parameter int PIX_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC_END  = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC_END  = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int PIPE_STAGES = 1
) (
  input logic           clk,
  input logic           rst_l,
  vga_scan_gen_if.master scan
);

  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_BLANK_PRE = 10'(V_ACT_END - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic          pixEn;

  logic [9:0]    hCount_q, hCount_d;
  logic [9:0]    vCount_q, vCount_d;

  logic          frameTick_q, frameTick_d;
  logic [7:0]    frameCount_q, frameCount_d;

  logic          brightRaw;
  logic          hSyncRaw;
  logic          vSyncRaw;
  logic [11:0]   rgbBlanked;

  logic          hPipe_q   [PIPE_STAGES];
  logic          vPipe_q   [PIPE_STAGES];
  logic [11:0]   rgbPipe_q [PIPE_STAGES];

  assign pixEn = (phase_q == PHASE_LAST);

  // Visible-area and sync decodes of the live counters.
  // The colour is blanked here, so every pipe stage carries already-blanked RGB.
  // That lets the pins come straight from flops, with no gating after the last stage.
  assign brightRaw  = (hCount_q >= 10'(H_ACT_START)) && (hCount_q < 10'(H_ACT_END)) &&
                      (vCount_q >= 10'(V_ACT_START)) && (vCount_q < 10'(V_ACT_END));
  assign hSyncRaw   = !(hCount_q < 10'(H_SYNC_END));
  assign vSyncRaw   = !(vCount_q < 10'(V_SYNC_END));
  assign rgbBlanked = brightRaw ? scan.rgb_in : 12'h000;

  // Next-state logic for the phase divider, scan counters and frame tick.
  always_comb begin
    phase_d      = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
    hCount_d     = hCount_q;
    vCount_d     = vCount_q;
    frameTick_d  = 1'b0;
    frameCount_d = frameCount_q;
    if (pixEn) begin
      if (hCount_q == H_LAST) begin
        hCount_d = '0;
        vCount_d = (vCount_q == V_LAST) ? '0 : vCount_q + 10'd1;
      end else begin
        hCount_d = hCount_q + 10'd1;
      end
      if ((hCount_q == H_LAST) && (vCount_q == V_BLANK_PRE)) begin
        frameTick_d  = 1'b1;
        frameCount_d = frameCount_q + 8'd1;
      end
    end
  end

  // Divider, scan counters and frame bookkeeping registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      phase_q      <= '0;
      hCount_q     <= '0;
      vCount_q     <= '0;
      frameTick_q  <= 1'b0;
      frameCount_q <= '0;
    end else begin
      phase_q      <= phase_d;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      frameTick_q  <= frameTick_d;
      frameCount_q <= frameCount_d;
    end
  end

  // Output pipe, shifted once per pixel at the end of its period.
  // This gives the colour logic several clocks to settle before capture.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        hPipe_q[i]   <= 1'b1;
        vPipe_q[i]   <= 1'b1;
        rgbPipe_q[i] <= 12'h000;
      end
    end else if (pixEn) begin
      hPipe_q[0]   <= hSyncRaw;
      vPipe_q[0]   <= vSyncRaw;
      rgbPipe_q[0] <= rgbBlanked;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        hPipe_q[i]   <= hPipe_q[i-1];
        vPipe_q[i]   <= vPipe_q[i-1];
        rgbPipe_q[i] <= rgbPipe_q[i-1];
      end
    end
  end

  assign scan.pix_en      = pixEn;
  assign scan.hCount      = hCount_q;
  assign scan.vCount      = vCount_q;
  assign scan.bright      = brightRaw;
  assign scan.hSync       = hPipe_q[PIPE_STAGES-1];
  assign scan.vSync       = vPipe_q[PIPE_STAGES-1];
  assign scan.rgb_out     = rgbPipe_q[PIPE_STAGES-1];
  assign scan.frame_tick  = frameTick_q;
  assign scan.frame_count = frameCount_q;

endmodule
